// File: rtl/serial_out_pkg.sv
// Shared definitions for the serial output scheduler and its engine:
// FSM state encoding, engine idle-mode codes and a width helper.
package serial_out_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  localparam logic [1:0] IDLE_LOW    = 2'd0;
  localparam logic [1:0] IDLE_HIGH   = 2'd1;
  localparam logic [1:0] IDLE_KEEP   = 2'd2;
  localparam logic [1:0] IDLE_REPEAT = 2'd3;

  // REPEAT is not a legal engine idle mode; it falls back to LOW
  function automatic logic [1:0] coerce_idle(input logic [1:0] m);
    return (m == IDLE_REPEAT) ? IDLE_LOW : m;
  endfunction

  function automatic int cw(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/serial_out_sched_rr_arbiter.sv
// Round-robin pick: first set request searching upward from ptr+1,
// wrapping; returns a one-hot grant and its index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  always_comb begin
    int j;
    logic [IW-1:0] w_j;
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = 1; i <= N; i++) begin
      j = int'(i_ptr) + i;
      if (j >= N) j = j - N;
      w_j = IW'(j);
      if (!o_valid && i_req[w_j]) begin
        o_valid    = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/serial_out_sched.sv
// Arbitrates NUM_CH requesters onto one serial output engine:
// start/stop/tick sequencing, watchdog and per-channel acks.
module serial_out_sched
  import serial_out_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_BIT    = 16,
  parameter int DIV_HIGH    = 2,
  parameter int DIV_LOW     = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          i_req,
  input  logic [NUM_CH*DATA_BIT-1:0] i_data,
  input  logic [NUM_CH-1:0]          i_freq_sel,
  input  logic [1:0]                 i_idle_mode,
  input  logic                       i_abort,
  input  logic                       i_so_done_tick,
  output logic                       o_so_start,
  output logic                       o_so_stop,
  output logic                       o_so_tick,
  output logic [1:0]                 o_so_idle_mode,
  output logic [DATA_BIT-1:0]        o_so_data,
  output logic [NUM_CH-1:0]          o_grant,
  output logic [NUM_CH-1:0]          o_ack,
  output logic                       o_timeout,
  output logic                       o_busy
);

  localparam int IW   = cw(NUM_CH);
  localparam int DMAX = (DIV_HIGH > DIV_LOW) ? DIV_HIGH : DIV_LOW;
  localparam int PW   = cw(DMAX);
  localparam int WW   = cw(TIMEOUT_CYC);

  localparam logic [PW-1:0] P_HI    = PW'(DIV_HIGH - 1);
  localparam logic [PW-1:0] P_LO    = PW'(DIV_LOW - 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);

  state_t r_state;
  state_t w_next;

  logic [IW-1:0]       r_ptr;
  logic [IW-1:0]       r_idx;
  logic [NUM_CH-1:0]   r_grant;
  logic [DATA_BIT-1:0] r_data;
  logic                r_freq;
  logic [PW-1:0]       r_pre;
  logic [WW-1:0]       r_wd;

  logic [NUM_CH-1:0] w_arb_grant;
  logic [IW-1:0]     w_arb_idx;
  logic              w_arb_valid;
  logic [PW-1:0]     w_pre_last;
  logic              w_tick;
  logic              w_wd_hit;
  logic              w_stop;
  logic              w_done;

  rr_arbiter #(
    .N  (NUM_CH),
    .IW (IW)
  ) u_arb (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  assign w_pre_last = r_freq ? P_HI : P_LO;

  always_comb begin
    w_next   = r_state;
    w_tick   = 1'b0;
    w_wd_hit = 1'b0;
    w_stop   = 1'b0;
    w_done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_arb_valid) w_next = S_START;
      end
      S_START: begin
        w_stop = i_abort;
        w_next = i_abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        w_tick   = (r_pre == w_pre_last);
        w_wd_hit = (r_wd == WD_LAST);
        // abort and watchdog both outrank a same-cycle done
        w_stop   = i_abort | w_wd_hit;
        if (w_stop)              w_next = S_IDLE;
        else if (i_so_done_tick) w_next = S_ACK;
      end
      S_ACK: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= IW'(NUM_CH - 1);
      r_idx   <= '0;
      r_grant <= '0;
      r_data  <= '0;
      r_freq  <= 1'b0;
      r_pre   <= '0;
      r_wd    <= '0;
    end else begin
      if (r_state == S_IDLE && w_arb_valid) begin
        r_idx   <= w_arb_idx;
        r_grant <= w_arb_grant;
        r_data  <= i_data[w_arb_idx*DATA_BIT +: DATA_BIT];
        r_freq  <= i_freq_sel[w_arb_idx];
      end
      if (r_state == S_START) begin
        r_pre <= '0;
        r_wd  <= '0;
      end
      if (r_state == S_RUN) begin
        r_pre <= w_tick ? '0 : r_pre + PW'(1);
        r_wd  <= r_wd + WW'(1);
      end
      if (w_stop || w_done) begin
        r_ptr   <= r_idx;
        r_grant <= '0;
      end
    end
  end

  assign o_so_start     = (r_state == S_START);
  assign o_so_stop      = w_stop;
  assign o_so_tick      = w_tick;
  assign o_timeout      = w_wd_hit;
  assign o_ack          = w_done ? r_grant : '0;
  assign o_grant        = r_grant;
  assign o_busy         = (r_state != S_IDLE);
  assign o_so_data      = r_data;
  assign o_so_idle_mode = coerce_idle(i_idle_mode);

endmodule

// File: tb/tb_serial_out_sched.sv
// Scoreboard bench: driver pushes expected transfers, monitor checks
// every cycle against a transfer-level model.
module tb_serial_out_sched;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int DH  = 2;
  localparam int DL  = 8;
  localparam int TO  = 20;

  localparam int K_DONE  = 0;
  localparam int K_ABORT = 1;
  localparam int K_TO    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    i_req;
  logic [NCH*DW-1:0] i_data;
  logic [NCH-1:0]    i_freq_sel;
  logic [1:0]        i_idle_mode;
  logic              i_abort;
  logic              i_so_done_tick;
  logic              o_so_start;
  logic              o_so_stop;
  logic              o_so_tick;
  logic [1:0]        o_so_idle_mode;
  logic [DW-1:0]     o_so_data;
  logic [NCH-1:0]    o_grant;
  logic [NCH-1:0]    o_ack;
  logic              o_timeout;
  logic              o_busy;

  always #5 clk = ~clk;

  serial_out_sched #(
    .NUM_CH      (NCH),
    .DATA_BIT    (DW),
    .DIV_HIGH    (DH),
    .DIV_LOW     (DL),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req          (i_req),
    .i_data         (i_data),
    .i_freq_sel     (i_freq_sel),
    .i_idle_mode    (i_idle_mode),
    .i_abort        (i_abort),
    .i_so_done_tick (i_so_done_tick),
    .o_so_start     (o_so_start),
    .o_so_stop      (o_so_stop),
    .o_so_tick      (o_so_tick),
    .o_so_idle_mode (o_so_idle_mode),
    .o_so_data      (o_so_data),
    .o_grant        (o_grant),
    .o_ack          (o_ack),
    .o_timeout      (o_timeout),
    .o_busy         (o_busy)
  );

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
    int            div;
    int            kind;
    int            d;
  } exp_t;

  exp_t sbq[$];
  exp_t pend;
  exp_t cur;
  exp_t m_e;
  int   tests = 0;
  int   fails = 0;
  int   ptr_m;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NCH-1:0] rq, input int p);
    for (int i = 1; i <= NCH; i++) begin
      int k;
      k = (p + i) % NCH;
      if (rq[k]) return k;
    end
    return -1;
  endfunction

  // ---------------- monitor ----------------
  int       c;
  int       last;
  bit       active = 1'b0;
  logic     pbusy = 1'b0;
  logic [NCH-1:0] preq = '0;

  task automatic check_cycle();
    int runend;
    logic [28:0] e;
    logic [28:0] a;
    logic e_tick, e_stop, e_to;
    logic [3:0] e_ack, e_gnt;
    runend = (m_e.kind == K_TO) ? TO : m_e.d;
    last   = (m_e.kind == K_DONE) ? m_e.d + 1 : runend;
    e_gnt  = 4'(1 << m_e.ch);
    e_tick = (c >= 1) && (c <= runend) && ((c % m_e.div) == 0);
    e_stop = (m_e.kind != K_DONE) && (c == runend);
    e_to   = (m_e.kind == K_TO) && (c == TO);
    e_ack  = (m_e.kind == K_DONE && c == m_e.d + 1) ? e_gnt : 4'd0;
    e = {c == 0, e_stop, e_tick, e_to, e_ack, e_gnt, 1'b1, m_e.data};
    a = {o_so_start, o_so_stop, o_so_tick, o_timeout, o_ack, o_grant,
         o_busy, o_so_data};
    chk($sformatf("cycle c=%0d ch=%0d kind=%0d", c, m_e.ch, m_e.kind), 64'(a), 64'(e));
    if (c >= last) active = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("idle_mode", 64'(o_so_idle_mode),
          64'((i_idle_mode == 2'd3) ? 2'd0 : i_idle_mode));
    end
    if (!mon_en) begin
      active = 1'b0;
    end else if (!active) begin
      chk("start_latency", 64'(o_so_start), 64'(!pbusy && preq != '0));
      if (o_so_start) begin
        chk("sb_empty", 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() != 0) begin
          m_e    = sbq.pop_front();
          active = 1'b1;
          c      = 0;
          check_cycle();
        end
      end else begin
        chk("idle_outputs",
            64'({o_so_stop, o_so_tick, o_timeout, o_ack, o_grant, o_busy}),
            64'd0);
      end
    end else begin
      c++;
      check_cycle();
    end
    pbusy = o_busy;
    preq  = i_req;
  end

  // ---------------- driver ----------------
  task automatic finish_tb();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    i_idle_mode = 2'($urandom);
  endtask

  task automatic scramble();
    i_data     = {$urandom, $urandom};
    i_freq_sel = 4'($urandom);
  endtask

  task automatic issue(input logic [NCH-1:0] rq, input logic [DW-1:0] dat,
                       input logic f, input int k, input int d);
    i_req = rq;
    if (rq == '0) return;
    pend.ch   = rr_pick(rq, ptr_m);
    pend.data = dat;
    pend.div  = f ? DH : DL;
    pend.kind = k;
    pend.d    = d;
    scramble();
    i_data[pend.ch*DW +: DW] = dat;
    i_freq_sel[pend.ch]      = f;
    sbq.push_back(pend);
  endtask

  task automatic wait_start();
    for (int n = 0; n < 300; n++) begin
      step();
      if (o_so_start) return;
    end
    chk("start_wait", 64'(o_so_start), 64'd1);
    finish_tb();
  endtask

  // serve the pending transfer; schedule the next one at its end
  task automatic serve(input logic [NCH-1:0] nrq, input logic [DW-1:0] nd,
                       input logic nf, input int nk, input int ndd);
    int tc;
    wait_start();
    cur   = pend;
    ptr_m = cur.ch;
    tc    = (cur.kind == K_TO) ? 11 : cur.d;
    if (tc == 0) begin
      i_abort        = 1'b1;
      i_so_done_tick = 1'b1;
      issue(nrq, nd, nf, nk, ndd);
    end else begin
      scramble();
      for (int j = 1; j <= tc; j++) begin
        step();
        if (j < tc) begin
          scramble();
        end else begin
          issue(nrq, nd, nf, nk, ndd);
          if (cur.kind == K_ABORT) begin
            i_abort        = 1'b1;
            i_so_done_tick = 1'b1;
          end else if (cur.kind == K_DONE) begin
            i_so_done_tick = 1'b1;
          end
        end
      end
    end
    step();
    i_abort        = 1'b0;
    i_so_done_tick = 1'b0;
    if (nrq == '0) begin
      for (int n = 0; n < 40 && o_busy; n++) step();
      for (int n = 0; n < 3; n++) begin
        step();
        i_abort        = 1'($urandom);
        i_so_done_tick = 1'($urandom);
      end
      step();
      i_abort        = 1'b0;
      i_so_done_tick = 1'b0;
    end
  endtask

  function automatic int rnd_kind();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 12) return K_DONE;
    if (r < 17) return K_ABORT;
    return K_TO;
  endfunction

  function automatic int rnd_d(input int k);
    if (k == K_DONE) return int'($urandom_range(1, 15));
    if (k == K_ABORT) return int'($urandom_range(0, 15));
    return 0;
  endfunction

  initial begin
    int k;
    logic [NCH-1:0] rq;
    i_req          = '0;
    i_data         = '0;
    i_freq_sel     = '0;
    i_idle_mode    = 2'd0;
    i_abort        = 1'b0;
    i_so_done_tick = 1'b0;
    rst            = 1'b1;
    repeat (3) step();
    chk("reset_outputs",
        64'({o_so_start, o_so_stop, o_so_tick, o_timeout, o_ack, o_grant,
             o_busy, o_so_data}), 64'd0);
    i_idle_mode = 2'd3;
    #1;
    chk("idle_coerce", 64'(o_so_idle_mode), 64'd0);
    rst    = 1'b0;
    ptr_m  = NCH - 1;
    mon_en = 1'b1;

    // fairness with all requests held, then single ch2 request
    issue(4'hF, 16'($urandom), 1'b1, K_DONE, 4);
    serve(4'hF, 16'($urandom), 1'b0, K_DONE, 9);
    serve(4'hF, 16'($urandom), 1'b1, K_DONE, 3);
    serve(4'hF, 16'($urandom), 1'b0, K_DONE, 12);
    serve(4'hF, 16'($urandom), 1'b1, K_DONE, 5);
    serve(4'b0100, 16'hA5A5, 1'b1, K_DONE, 6);
    serve(4'b0000, 16'h0, 1'b0, K_DONE, 1);

    // watchdog, then abort coinciding with done
    step();
    issue(4'b0010, 16'($urandom), 1'b0, K_TO, 0);
    serve(4'b1011, 16'($urandom), 1'b1, K_ABORT, 5);
    serve(4'b1011, 16'($urandom), 1'b0, K_ABORT, 0);

    for (int t = 0; t < 40; t++) begin
      rq = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      k  = rnd_kind();
      serve(rq, 16'($urandom), 1'($urandom), k, rnd_d(k));
      if (rq == '0) begin
        k = rnd_kind();
        issue(4'($urandom_range(1, 15)), 16'($urandom), 1'($urandom),
              k, rnd_d(k));
      end
    end
    serve(4'b0000, 16'h0, 1'b0, K_DONE, 1);

    // reset in the middle of a run
    step();
    issue(4'b0001, 16'($urandom), 1'b1, K_DONE, 15);
    wait_start();
    repeat (5) step();
    step();
    rst   = 1'b1;
    i_req = '0;
    step();
    mon_en = 1'b0;
    rst    = 1'b0;
    chk("reset_mid_run",
        64'({o_so_start, o_so_stop, o_so_tick, o_timeout, o_ack, o_grant,
             o_busy, o_so_data}), 64'd0);
    sbq.delete();
    ptr_m = NCH - 1;
    step();
    mon_en = 1'b1;
    issue(4'hF, 16'($urandom), 1'b0, K_DONE, 2);
    serve(4'b0000, 16'h0, 1'b0, K_DONE, 1);
    repeat (4) step();
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    finish_tb();
  end

endmodule
